// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Moore-style multicycle MIPS control FSM with memory wait states.
//            Define CTRL_ADDI_EN to add addi (opcode 0x08) support.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int MEM_WAIT = 0,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemToReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                Branch,
    output logic                Jump,
    output logic [1:0]          PCSource,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXEC    = STATE_W'(6),
        S_RTYPEWB = STATE_W'(7),
        S_BRANCH  = STATE_W'(8),
        S_JUMP    = STATE_W'(9)
`ifdef CTRL_ADDI_EN
        ,
        S_ADDIEX  = STATE_W'(10),
        S_ADDIWB  = STATE_W'(11)
`endif
    } state_e;

    localparam logic [OPCODE_W-1:0] c_OP_RTYPE = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] c_OP_LW    = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] c_OP_SW    = OPCODE_W'(6'h2B);
    localparam logic [OPCODE_W-1:0] c_OP_BEQ   = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] c_OP_J     = OPCODE_W'(6'h02);
`ifdef CTRL_ADDI_EN
    localparam logic [OPCODE_W-1:0] c_OP_ADDI  = OPCODE_W'(6'h08);
`endif
    localparam logic [3:0]          c_WAIT_LAST = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       illegal_q, illegal_d;

    logic               w_pcw, w_pcwc, w_iord, w_mrd, w_mwr, w_irw;
    logic               w_m2r, w_rdst, w_rw, w_asrc, w_br, w_jmp;
    logic [1:0]         w_asrcb, w_pcsrc;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_wait_last;

    assign w_wait_last = (wcnt_q == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wcnt_q    <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            if (!stall) begin
                state_q <= state_d;
                wcnt_q  <= wcnt_d;
            end
        end
    end

    // Wait counter clears by default; memory states step it until the last wait cycle.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = 4'd0;
        illegal_d = 1'b0;
        w_pcw     = 1'b0;
        w_pcwc    = 1'b0;
        w_iord    = 1'b0;
        w_mrd     = 1'b0;
        w_mwr     = 1'b0;
        w_irw     = 1'b0;
        w_m2r     = 1'b0;
        w_rdst    = 1'b0;
        w_rw      = 1'b0;
        w_asrc    = 1'b0;
        w_br      = 1'b0;
        w_jmp     = 1'b0;
        w_asrcb   = 2'd0;
        w_pcsrc   = 2'd0;
        w_aluop   = ALUOP_W'(0);
        case (state_q)
            S_FETCH: begin
                w_mrd   = 1'b1;
                w_asrcb = 2'd1;
                if (w_wait_last) begin
                    w_irw   = 1'b1;
                    w_pcw   = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                w_asrcb = 2'd3;
                case (opcode)
                    c_OP_RTYPE:       state_d = S_EXEC;
                    c_OP_LW, c_OP_SW: state_d = S_MEMADR;
                    c_OP_BEQ:         state_d = S_BRANCH;
                    c_OP_J:           state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
                    c_OP_ADDI:        state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = ~stall;
                    end
                endcase
            end
            S_MEMADR: begin
                w_asrc  = 1'b1;
                w_asrcb = 2'd2;
                if (opcode == c_OP_SW)
                    state_d = S_MEMWR;
                else if (opcode == c_OP_LW)
                    state_d = S_MEMRD;
                else
                    state_d = S_FETCH;
            end
            S_MEMRD: begin
                w_mrd  = 1'b1;
                w_iord = 1'b1;
                if (w_wait_last) state_d = S_MEMWB;
                else             wcnt_d  = wcnt_q + 4'd1;
            end
            S_MEMWB: begin
                w_rw    = 1'b1;
                w_m2r   = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                w_mwr  = 1'b1;
                w_iord = 1'b1;
                if (w_wait_last) state_d = S_FETCH;
                else             wcnt_d  = wcnt_q + 4'd1;
            end
            S_EXEC: begin
                w_asrc  = 1'b1;
                w_aluop = ALUOP_W'(2);
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_rw    = 1'b1;
                w_rdst  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                w_asrc  = 1'b1;
                w_aluop = ALUOP_W'(1);
                w_pcwc  = 1'b1;
                w_pcsrc = 2'd1;
                w_br    = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                w_pcw   = 1'b1;
                w_pcsrc = 2'd2;
                w_jmp   = 1'b1;
                state_d = S_FETCH;
            end
`ifdef CTRL_ADDI_EN
            S_ADDIEX: begin
                w_asrc  = 1'b1;
                w_asrcb = 2'd2;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_rw    = 1'b1;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Write strobes are suppressed by stall; everything but state is silenced by reset.
    assign PCWrite     = w_pcw  & ~stall & ~reset;
    assign PCWriteCond = w_pcwc & ~stall & ~reset;
    assign IRWrite     = w_irw  & ~stall & ~reset;
    assign RegWrite    = w_rw   & ~stall & ~reset;
    assign MemWrite    = w_mwr  & ~stall & ~reset;
    assign IorD        = w_iord & ~reset;
    assign MemRead     = w_mrd  & ~reset;
    assign MemToReg    = w_m2r  & ~reset;
    assign RegDst      = w_rdst & ~reset;
    assign ALUSrc      = w_asrc & ~reset;
    assign Branch      = w_br   & ~reset;
    assign Jump        = w_jmp  & ~reset;
    assign ALUSrcB     = reset ? 2'd0 : w_asrcb;
    assign PCSource    = reset ? 2'd0 : w_pcsrc;
    assign ALUOp       = reset ? ALUOP_W'(0) : w_aluop;
    assign illegal     = illegal_q & ~reset;
    assign state       = state_q;

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Parametrised multicycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one unified memory. Memory access takes a configurable number of wait cycles. The existing control outputs (RegDst, Jump, Branch, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp) keep their names, and the multicycle datapath enables are added alongside them.

Parameters:
OPCODE_W, 6, opcode field width (instruction bits [31:26])
ALUOP_W, 2, ALUOp width
MEM_WAIT, 0, extra wait cycles per memory access (0..15)
STATE_W, 4, state register width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  OPCODE_W  instruction opcode, taken from the IR
stall  input  1  freezes the FSM and the wait counter while high
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU zero (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read
MemWrite  output  1  memory write
IRWrite  output  1  instruction register load
MemToReg  output  1  write-back data select: 1 = MDR
RegDst  output  1  destination register: 1 = rd, 0 = rt
RegWrite  output  1  register file write
ALUSrc  output  1  ALU A select: 0 = PC, 1 = rs
ALUSrcB  output  2  ALU B select: 0 = rt, 1 = 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left 2
ALUOp  output  ALUOP_W  ALU operation: 0 = add, 1 = sub, 2 = funct
Branch  output  1  high in the BRANCH state
Jump  output  1  high in the JUMP state
PCSource  output  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target
illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode
state  output  STATE_W  current state, for debug and monitoring

Behaviour:
- Reset (synchronous, active-high): state <= FETCH, wait counter <= 0. While reset is high, every output except state is driven to 0.
- Outputs are Moore, decoded from state and the wait counter only. The exception is illegal, which is registered.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- FETCH:
  - MemRead=1, IorD=0, ALUSrc=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - Stays in FETCH for MEM_WAIT+1 cycles. IRWrite and PCWrite are asserted only in the final cycle, then the FSM moves to DECODE.
- DECODE: ALUSrc=0, ALUSrcB=3, ALUOp=0. Next state by opcode:
  - 0x00 -> EXEC
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX (only when the option is enabled)
  - anything else -> FETCH, with illegal=1 on the next cycle
- MEMADR: ALUSrc=1, ALUSrcB=2, ALUOp=0. Next state is MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: MemRead=1, IorD=1, held for MEM_WAIT+1 cycles, then MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0, then FETCH.
- MEMWR: MemWrite=1, IorD=1, held for MEM_WAIT+1 cycles, then FETCH.
- EXEC: ALUSrc=1, ALUSrcB=0, ALUOp=2, then RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=1, MemToReg=0, then FETCH.
- BRANCH: ALUSrc=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, Branch=1, then FETCH.
- JUMP: PCWrite=1, PCSource=2, Jump=1, then FETCH.
- Instruction latency with MEM_WAIT=0:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each memory state adds MEM_WAIT cycles.
- Wait counter:
  - Counts 0..MEM_WAIT inside a memory state.
  - Clears on every state change.
  - Never wraps past MEM_WAIT.
- stall=1: the state and wait counter hold their values. Write strobes (PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite) are forced to 0 during stall. Other outputs stay unchanged.
- Simultaneous events: reset has priority over stall. With reset and stall both high, the FSM still goes to FETCH.
- Reset in mid-instruction: the FSM goes to FETCH on the next edge. No partial write strobe is emitted in the reset cycle.
- opcode is sampled only in DECODE and MEMADR. Changes at any other time are ignored.

Optional Feature:
CTRL_ADDI_EN
- Defined: opcode 0x08 is supported.
  - DECODE -> ADDIEX: ALUSrc=1, ALUSrcB=2, ALUOp=0.
  - ADDIEX -> ADDIWB: RegWrite=1, RegDst=0, MemToReg=0.
  - ADDIWB -> FETCH.
- Undefined: the ADDIEX and ADDIWB states do not exist. Opcode 0x08 is illegal and follows the illegal-opcode path.

Test Plan:
- Reset, then release; opcode=0x00, MEM_WAIT=0 -> all outputs are 0 during reset; state sequence 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7.
- opcode=0x23, MEM_WAIT=2 -> FETCH lasts 3 cycles with IRWrite only in the 3rd; MEMRD lasts 3 cycles with IorD=1; the whole instruction takes 9 cycles.
- opcode=0x2B -> MemWrite=1 for exactly MEM_WAIT+1 cycles; RegWrite is never asserted.
- opcode=0x04, then opcode=0x02 -> BRANCH shows PCWriteCond=1, ALUOp=1, PCSource=1; JUMP shows PCWrite=1, PCSource=2; both return to FETCH.
- opcode=0x3F -> DECODE returns to FETCH and illegal pulses for exactly 1 cycle. Opcode 0x08 gives the same result without CTRL_ADDI_EN; with it, the sequence is states 10 then 11 and RegWrite=1 in state 11.
- stall=1 for 4 cycles in MEMWR, then reset asserted in MEMRD -> during stall the state holds and MemWrite=0; after reset the next state is FETCH with no RegWrite pulse.
